// File: rtl/addr_calc_arb_if.sv
// Shared RAM address bus: registered address, valid and direction.
// master drives addr/addr_valid/addr_wr, slave observes them.
interface addr_calc_arb_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              addr_wr;

  modport master (
    output addr,
    output addr_valid,
    output addr_wr
  );

  modport slave (
    input addr,
    input addr_valid,
    input addr_wr
  );
endinterface

// File: rtl/addr_calc_arb.sv
// Address generator and read/write arbiter for N_CH accelerator channels.
// Ports: clk/rst, offset/filesize job setup, ch_enable, rd/wr_pause,
//   bus (addr/addr_valid/addr_wr), rd_done/wr_done, busy, err.
module addr_calc_arb #(
  parameter int ADDR_W       = 32,
  parameter int N_CH         = 3,
  parameter int STRIDE_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] offset,
  input  logic [ADDR_W-1:0] filesize,
  input  logic [N_CH-1:0]   ch_enable,
  input  logic [N_CH-1:0]   rd_pause,
  input  logic [N_CH-1:0]   wr_pause,
  addr_calc_arb_if.master   bus,
  output logic [N_CH-1:0]   rd_done,
  output logic [N_CH-1:0]   wr_done,
  output logic              busy,
  output logic              err
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] words;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] wr_cnt;
  logic [CH_W-1:0]   ch;
  logic              last_wr;
  logic [N_CH-1:0]   en_q;

  logic [CH_W-1:0]   en_idx;
  logic [N_CH-1:0]   ch_mask;
  logic [N_CH-1:0]   rise;
  logic              onehot;
  logic              multi;
  logic              en_ch;
  logic              fin;
  logic              rd_ok;
  logic              wr_ok;
  logic              go;
  logic              gnt_rd;
  logic              gnt_wr;
  logic              err_n;

  always_comb begin
    en_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_enable[i]) en_idx = CH_W'(i);
    end
  end

  assign onehot  = (ch_enable != '0) &&
                   ((ch_enable & (ch_enable - 1'b1)) == '0);
  assign multi   = (ch_enable != '0) && !onehot;
  assign ch_mask = N_CH'(1) << ch;
  assign rise    = ch_enable & ~en_q;
  assign en_ch   = ch_enable[ch];
  assign fin     = (rd_cnt == words) && (wr_cnt == words);

  // A write may only follow a word that has already been read.
  assign rd_ok = (rd_cnt < words) && !rd_pause[ch];
  assign wr_ok = (wr_cnt < rd_cnt) && !wr_pause[ch];
  assign go    = (state == S_RUN) && en_ch && !fin;

  // Contested grants alternate; last_wr starts at 1 so read wins first.
  assign gnt_rd = go && rd_ok && (!wr_ok || last_wr);
  assign gnt_wr = go && wr_ok && !gnt_rd;

  // err fires on the edge of a bad pattern, not for as long as it is held.
  assign err_n =
    ((state == S_IDLE) && multi && (rise != '0)) ||
    ((state == S_RUN) && en_ch && ((rise & ~ch_mask) != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      base           <= '0;
      words          <= '0;
      rd_cnt         <= '0;
      wr_cnt         <= '0;
      ch             <= '0;
      last_wr        <= 1'b1;
      en_q           <= '0;
      err            <= 1'b0;
      bus.addr       <= '0;
      bus.addr_valid <= 1'b0;
      bus.addr_wr    <= 1'b0;
    end else begin
      en_q           <= ch_enable;
      err            <= err_n;
      bus.addr_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (onehot) begin
            base    <= offset;
            words   <= filesize >> STRIDE_SHIFT;
            ch      <= en_idx;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            last_wr <= 1'b1;
            if ((filesize >> STRIDE_SHIFT) == '0)
              state <= S_DONE;
            else
              state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!en_ch) begin
            state <= S_IDLE;
          end else if (fin) begin
            state <= S_DONE;
          end else begin
            unique case (1'b1)
              gnt_rd: begin
                bus.addr       <= base + rd_cnt;
                bus.addr_wr    <= 1'b0;
                bus.addr_valid <= 1'b1;
                rd_cnt         <= rd_cnt + 1'b1;
                last_wr        <= 1'b0;
              end
              gnt_wr: begin
                bus.addr       <= base + wr_cnt;
                bus.addr_wr    <= 1'b1;
                bus.addr_valid <= 1'b1;
                wr_cnt         <= wr_cnt + 1'b1;
                last_wr        <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_DONE: begin
          if (!en_ch) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_done = '0;
    wr_done = '0;
    if (state != S_IDLE) begin
      rd_done[ch] = (rd_cnt == words);
      wr_done[ch] = (wr_cnt == words);
    end
  end

  assign busy = (state == S_RUN);

endmodule

// File: tb/tb_addr_calc_arb.sv
// Self-checking bench for addr_calc_arb: directed jobs plus random
// jobs with random back-pressure against a reference model.
module tb_addr_calc_arb;
  localparam int AW = 32;
  localparam int NC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] offset;
  logic [AW-1:0] filesize;
  logic [NC-1:0] ch_enable;
  logic [NC-1:0] rd_pause;
  logic [NC-1:0] wr_pause;
  logic [NC-1:0] rd_done;
  logic [NC-1:0] wr_done;
  logic          busy;
  logic          err;

  addr_calc_arb_if #(.ADDR_W(AW)) bus ();

  addr_calc_arb #(
    .ADDR_W(AW), .N_CH(NC), .STRIDE_SHIFT(2)
  ) dut (
    .clk(clk), .rst(rst),
    .offset(offset), .filesize(filesize),
    .ch_enable(ch_enable),
    .rd_pause(rd_pause), .wr_pause(wr_pause),
    .bus(bus),
    .rd_done(rd_done), .wr_done(wr_done),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: job phase 0=idle 1=running 2=finished
  int          ph;
  int unsigned m_words, m_nr, m_nw;
  int          m_ch;
  logic [AW-1:0] m_base, m_addr;
  bit          m_last_wr, m_valid, m_wr, m_err;
  logic [NC-1:0] m_prev;

  logic [AW:0] dut_trace[$];
  int unsigned dut_rd_seen;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [NC-1:0] rise;
    logic [NC-1:0] own;
    bit rok, wok, pick_wr;
    rise    = ch_enable & ~m_prev;
    m_valid = 0;
    m_err   = 0;
    if (rst) begin
      ph = 0; m_nr = 0; m_nw = 0; m_last_wr = 1;
      m_addr = '0; m_wr = 0; m_ch = 0; m_words = 0;
      m_prev = '0;
    end else begin
      if (ph == 0) begin
        if ($countones(ch_enable) == 1) begin
          m_base  = offset;
          m_words = filesize / 4;
          for (int i = 0; i < NC; i++)
            if (ch_enable[i]) m_ch = i;
          m_nr = 0; m_nw = 0; m_last_wr = 1;
          ph = (m_words == 0) ? 2 : 1;
        end else if ($countones(ch_enable) > 1 && rise != 0) begin
          m_err = 1;
        end
      end else if (ph == 1) begin
        own = '0;
        own[m_ch] = 1'b1;
        if (!ch_enable[m_ch]) begin
          ph = 0;
        end else begin
          if ((rise & ~own) != 0) m_err = 1;
          if (m_nr == m_words && m_nw == m_words) begin
            ph = 2;
          end else begin
            rok = (m_nr < m_words) && !rd_pause[m_ch];
            wok = (m_nw < m_nr) && !wr_pause[m_ch];
            pick_wr = (rok && wok) ? !m_last_wr : wok;
            if (rok || wok) begin
              m_valid = 1;
              m_wr = pick_wr;
              if (pick_wr) begin
                m_addr = m_base + m_nw;
                m_nw++;
              end else begin
                m_addr = m_base + m_nr;
                m_nr++;
              end
              m_last_wr = pick_wr;
            end
          end
        end
      end else begin
        if (!ch_enable[m_ch]) ph = 0;
      end
      m_prev = ch_enable;
    end
  endtask

  task automatic step();
    logic [NC-1:0] exp_rd, exp_wd;
    model_edge();
    @(posedge clk);
    #1;
    exp_rd = '0;
    exp_wd = '0;
    if (ph != 0) begin
      exp_rd[m_ch] = (m_nr == m_words);
      exp_wd[m_ch] = (m_nw == m_words);
    end
    chk("valid", bus.addr_valid, m_valid);
    chk("addr", bus.addr, m_addr);
    if (m_valid) chk("dir", bus.addr_wr, m_wr);
    chk("busy", busy, ph == 1);
    chk("rd_done", rd_done, exp_rd);
    chk("wr_done", wr_done, exp_wd);
    chk("err", err, m_err);
    if (bus.addr_valid === 1'b1) begin
      dut_trace.push_back({bus.addr_wr, bus.addr});
      if (bus.addr_wr === 1'b1)
        chk("wr_after_rd",
            (bus.addr - m_base) < dut_rd_seen, 1);
      else
        dut_rd_seen++;
    end
  endtask

  task automatic rand_pause(int pct);
    for (int i = 0; i < NC; i++) begin
      rd_pause[i] = ($urandom_range(99) < pct);
      wr_pause[i] = ($urandom_range(99) < pct);
    end
  endtask

  task automatic start(int ch, logic [AW-1:0] off,
                       logic [AW-1:0] fs);
    ch_enable = '0;
    ch_enable[ch] = 1'b1;
    offset   = off;
    filesize = fs;
    dut_trace.delete();
    dut_rd_seen = 0;
    step();
  endtask

  task automatic run_to_done(int budget, int pct);
    int n = 0;
    while (ph != 2 && n < budget) begin
      rand_pause(pct);
      step();
      n++;
    end
    chk("job_finished", busy, 1'b0);
    rd_pause = '0;
    wr_pause = '0;
  endtask

  task automatic release_job();
    ch_enable = '0;
    step();
    step();
  endtask

  task automatic check_alt(logic [AW-1:0] b, int w);
    chk("trace_len", dut_trace.size(), 2 * w);
    for (int k = 0; k < w && 2 * k + 1 < dut_trace.size(); k++) begin
      chk("trace_rd", dut_trace[2*k], {1'b0, b + AW'(k)});
      chk("trace_wr", dut_trace[2*k+1], {1'b1, b + AW'(k)});
    end
  endtask

  initial begin
    logic [AW-1:0] rd_addrs[$];
    logic [AW-1:0] b;
    int w;

    rst = 1'b1;
    offset = '0;
    filesize = '0;
    ch_enable = '0;
    rd_pause = '0;
    wr_pause = '0;
    dut_rd_seen = 0;
    m_prev = '0;
    step();
    chk("rst_addr", bus.addr, 0);
    chk("rst_wr", bus.addr_wr, 0);
    rst = 1'b0;
    step();

    // basic job, channel 1
    start(1, 32'h100, 16);
    run_to_done(40, 0);
    step();
    step();
    chk("done_hold", {rd_done, wr_done}, {3'b010, 3'b010});
    check_alt(32'h100, 4);
    release_job();

    // read back-pressure at job start
    rd_pause = '1;
    start(0, 32'h2000, 40);
    for (int i = 0; i < 4; i++) step();
    run_to_done(200, 30);
    release_job();

    // zero-size job
    start(2, 32'h500, 3);
    step();
    chk("zero_done", {rd_done, wr_done}, {3'b100, 3'b100});
    release_job();

    // address wrap
    start(1, 32'hFFFF_FFFE, 16);
    run_to_done(40, 0);
    foreach (dut_trace[i])
      if (!dut_trace[i][AW]) rd_addrs.push_back(dut_trace[i][AW-1:0]);
    chk("wrap_n", rd_addrs.size(), 4);
    if (rd_addrs.size() == 4) begin
      chk("wrap0", rd_addrs[0], 32'hFFFF_FFFE);
      chk("wrap1", rd_addrs[1], 32'hFFFF_FFFF);
      chk("wrap2", rd_addrs[2], 32'h0);
      chk("wrap3", rd_addrs[3], 32'h1);
    end
    release_job();

    // abort after 3 reads, then restart at base
    start(0, 32'h40, 64);
    for (int i = 0; i < 20 && m_nr < 3; i++) step();
    ch_enable = '0;
    step();
    chk("abort_done", {rd_done, wr_done}, 0);
    step();
    start(0, 32'h40, 64);
    step();
    chk("restart_n", dut_trace.size(), 1);
    if (dut_trace.size() >= 1)
      chk("restart_addr", dut_trace[0], {1'b0, 32'h40});
    run_to_done(100, 0);
    release_job();

    // reset mid-job
    start(2, 32'h900, 32);
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    step();
    chk("mrst_out",
        {bus.addr, bus.addr_valid, bus.addr_wr,
         rd_done, wr_done, busy, err}, 0);
    rst = 1'b0;
    ch_enable = '0;
    step();

    // illegal pattern in idle
    ch_enable = 3'b011;
    step();
    chk("ill_err", err, 1);
    chk("ill_busy", busy, 0);
    ch_enable = '0;
    step();

    // extra enable during a channel-0 job
    start(0, 32'h300, 24);
    for (int i = 0; i < 3; i++) step();
    ch_enable = 3'b101;
    step();
    chk("run_err", err, 1);
    run_to_done(40, 0);
    check_alt(32'h300, 6);
    release_job();

    // random jobs with random back-pressure
    for (int j = 0; j < 20; j++) begin
      b = $urandom();
      w = $urandom_range(0, 60);
      start($urandom_range(0, NC - 1), b, AW'(w));
      run_to_done(4 * w + 50, $urandom_range(0, 60));
      release_job();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
